// File: rtl/pkg_dtypes.sv
// Shared datapath types for the front-end: EU count and the issue-queue entry payload.
package pkg_dtypes;

    localparam int unsigned LOG2_NUM_EXEC_UNITS = 2;
    localparam int unsigned NUM_EXEC_UNITS      = 1 << LOG2_NUM_EXEC_UNITS;

    // Renamed instruction as carried on the dispatch bus into each EU queue.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [5:0]  rd_phys;
        logic [5:0]  rs1_phys;
        logic [5:0]  rs2_phys;
        logic [15:0] imm;
    } type_iqueue_entry;

endpackage

// File: rtl/fe_instr_dispatcher.sv
// Front-end dispatch stage: captures a renamed batch, assigns EUs round-robin to valid lanes,
// and re-drives refused lanes on the shared dispatch bus until the whole batch is accepted.
module fe_instr_dispatcher
    import pkg_dtypes::*;
#(
    parameter int unsigned NUM_PARALLEL_INSTR_DISPATCHES = 4,
    parameter int unsigned STALL_CTR_WIDTH               = 16
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  type_iqueue_entry                         batch_instr_i [NUM_PARALLEL_INSTR_DISPATCHES],
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0] batch_instr_valid_i,
    input  logic                                     batch_valid_i,
    output logic                                     batch_ready_o,
    output type_iqueue_entry                         dispatched_instr_o [NUM_PARALLEL_INSTR_DISPATCHES],
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0] dispatched_instr_valid_o,
    output logic [LOG2_NUM_EXEC_UNITS-1:0]           dispatched_instr_alloc_euidx_o [NUM_PARALLEL_INSTR_DISPATCHES],
    input  logic [NUM_EXEC_UNITS-1:0]                eu_is_full_i,
    output logic                                     busy_o,
    output logic [STALL_CTR_WIDTH-1:0]               stall_cycles_o
);

    localparam int unsigned N    = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int unsigned EU_W = LOG2_NUM_EXEC_UNITS;

    typedef enum logic {
        IDLE,
        DISPATCH
    } state_e;

    state_e                     state_q, state_d;
    logic [N-1:0]               pending_q, pending_d;
    type_iqueue_entry           payload_q [N];
    type_iqueue_entry           payload_d [N];
    logic [EU_W-1:0]            euidx_q [N];
    logic [EU_W-1:0]            euidx_d [N];
    logic [EU_W-1:0]            rr_euidx_q, rr_euidx_d;
    logic [STALL_CTR_WIDTH-1:0] stall_q, stall_d;

    logic [N-1:0]               retire;
    logic [N-1:0]               refused;
    logic                       capture;
    logic [EU_W-1:0]            lane_k;

    // A pending lane retires when the EU it targets has room this cycle.
    always_comb begin
        retire = '0;
        for (int i = 0; i < N; i++) begin
            retire[i] = pending_q[i] & ~eu_is_full_i[euidx_q[i]];
        end
    end

    // Ready whenever nothing will remain pending after this edge, so batches flow without bubbles.
    assign refused       = pending_q & ~retire;
    assign batch_ready_o = (refused == '0);
    assign capture       = batch_valid_i & batch_ready_o;

    // Next-state: retire accepted lanes, load a new batch with round-robin EU allocation, count stalls.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q & ~retire;
        payload_d  = payload_q;
        euidx_d    = euidx_q;
        rr_euidx_d = rr_euidx_q;
        stall_d    = stall_q;
        lane_k     = '0;

        for (int i = 0; i < N; i++) begin
            if (retire[i]) begin
                payload_d[i] = '0;
                euidx_d[i]   = '0;
            end
        end

        if ((refused != '0) && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CTR_WIDTH'(1);
        end

        if (capture) begin
            for (int i = 0; i < N; i++) begin
                pending_d[i] = batch_instr_valid_i[i];
                if (batch_instr_valid_i[i]) begin
                    payload_d[i] = batch_instr_i[i];
                    euidx_d[i]   = rr_euidx_q + lane_k;
                    lane_k       = lane_k + EU_W'(1);
                end else begin
                    payload_d[i] = '0;
                    euidx_d[i]   = '0;
                end
            end
            // lane_k wraps at EU_W bits, i.e. popcount mod NUM_EU.
            rr_euidx_d = rr_euidx_q + lane_k;
        end

        case (state_q)
            IDLE:     if (pending_d != '0) state_d = DISPATCH;
            DISPATCH: if (pending_d == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partially dispatched batch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            rr_euidx_q <= '0;
            stall_q    <= '0;
            for (int i = 0; i < N; i++) begin
                payload_q[i] <= '0;
                euidx_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            payload_q  <= payload_d;
            euidx_q    <= euidx_d;
            rr_euidx_q <= rr_euidx_d;
            stall_q    <= stall_d;
        end
    end

    assign dispatched_instr_o             = payload_q;
    assign dispatched_instr_valid_o       = pending_q;
    assign dispatched_instr_alloc_euidx_o = euidx_q;
    assign busy_o                         = (state_q == DISPATCH);
    assign stall_cycles_o                 = stall_q;

endmodule
